// File: rtl/dffr_rst_seq_ctrl.sv
// Reset-release sequencer: synchronises RN deassertion, then releases domain resets
// one at a time with a programmable gap and per-domain acknowledge / timeout.
module dffr_rst_seq_ctrl #(
    parameter int unsigned NDOM        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IDX_W       = 2
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             sw_rst_req,
    input  logic [NDOM-1:0]  dom_ack,
    output logic [NDOM-1:0]  dom_rn,
    output logic [IDX_W-1:0] seq_idx,
    output logic             seq_busy,
    output logic             seq_done,
    output logic             seq_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GAP  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDOM - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_d;
    logic [NDOM-1:0]        dom_rn_d;
    logic                   busy_d, done_d, err_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rn_ok;
    logic                   ack_cur;
    logic [NDOM-1:0]        rel_mask;

    // RN deassertion synchroniser; assertion stays asynchronous
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rn_ok    = sync_q[SYNC_STAGES-1];
    assign ack_cur  = dom_ack[seq_idx];
    assign rel_mask = NDOM'(1) << seq_idx;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            seq_idx  <= '0;
            dom_rn   <= '0;
            seq_busy <= 1'b0;
            seq_done <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seq_idx  <= idx_d;
            dom_rn   <= dom_rn_d;
            seq_busy <= busy_d;
            seq_done <= done_d;
            seq_err  <= err_d;
        end
    end

    // Next-state and next-output logic; every register holds unless a transition fires
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = seq_idx;
        dom_rn_d = dom_rn;
        busy_d   = seq_busy;
        done_d   = seq_done;
        err_d    = seq_err;

        unique case (state_q)
            S_IDLE: begin
                if (rn_ok) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    dom_rn_d = dom_rn | rel_mask;
                    cnt_d    = '0;
                    state_d  = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // An ack on the timeout edge takes priority over the error
            S_WAIT: begin
                if (ack_cur) begin
                    cnt_d = '0;
                    if (seq_idx == IDX_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = seq_idx + IDX_W'(1);
                        state_d = S_GAP;
                    end
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_ERR;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE, S_ERR: begin
                if (sw_rst_req) begin
                    dom_rn_d = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_GAP;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dffr_rst_seq_ctrl.sv
// Bench for dffr_rst_seq_ctrl: event-time reference model compared every cycle,
// directed scenarios with literal timing checks, then a randomized soak.
module tb_dffr_rst_seq_ctrl;

    localparam int NDOM = 4;
    localparam int SYNC = 2;
    localparam int GAP  = 8;
    localparam int ATO  = 255;
    localparam int NONE = -100000;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [3:0] dom_ack = 4'b0000;
    logic [3:0] dom_rn;
    logic [1:0] seq_idx;
    logic       seq_busy, seq_done, seq_err;

    dffr_rst_seq_ctrl #(
        .NDOM(NDOM), .SYNC_STAGES(SYNC), .GAP_CYC(GAP), .ACK_TIMEOUT(ATO),
        .CNT_W(8), .IDX_W(2)
    ) dut (
        .CK(CK), .RN(RN), .sw_rst_req(sw_rst_req), .dom_ack(dom_ack),
        .dom_rn(dom_rn), .seq_idx(seq_idx), .seq_busy(seq_busy),
        .seq_done(seq_done), .seq_err(seq_err)
    );

    always #5 CK = ~CK;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int mode   = 0;
    int e0     = 0;
    int t_sw   = 0;
    int rel_cyc [4];
    int err_cyc, done_cyc, busy_cyc;
    logic [3:0] prev_rn   = 4'b0000;
    logic       prev_err  = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_busy = 1'b0;

    // Reference model: tracks when things must happen, as edge numbers
    int         m_rnhi, m_idx, m_gap_end, m_rel;
    bit         m_started, m_gap, m_wait, m_done, m_err;
    logic [3:0] m_rn;

    task automatic model_reset();
        m_rnhi = 0; m_idx = 0; m_gap_end = 0; m_rel = 0;
        m_started = 0; m_gap = 0; m_wait = 0; m_done = 0; m_err = 0;
        m_rn = 4'b0000;
    endtask

    task automatic model_edge();
        if (!RN) begin
            model_reset();
        end else begin
            if (m_rnhi <= SYNC) m_rnhi++;
            if (!m_started) begin
                if (m_rnhi > SYNC) begin
                    m_started = 1; m_gap = 1; m_idx = 0; m_gap_end = cyc + GAP;
                end
            end else if (m_gap) begin
                if (cyc == m_gap_end) begin
                    m_rn[m_idx] = 1'b1; m_gap = 0; m_wait = 1; m_rel = cyc;
                end
            end else if (m_wait) begin
                if (dom_ack[m_idx]) begin
                    m_wait = 0;
                    if (m_idx == NDOM - 1) m_done = 1;
                    else begin
                        m_idx++; m_gap = 1; m_gap_end = cyc + GAP;
                    end
                end else if (cyc - m_rel == ATO) begin
                    m_wait = 0; m_err = 1;
                end
            end else if (sw_rst_req) begin
                m_rn = 4'b0000; m_done = 0; m_err = 0; m_idx = 0;
                m_gap = 1; m_gap_end = cyc + GAP;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic compare();
        if (!RN) begin
            chk("rst_dom_rn", 32'(dom_rn), 32'd0);
            chk("rst_seq_idx", 32'(seq_idx), 32'd0);
            chk("rst_flags", {29'd0, seq_busy, seq_done, seq_err}, 32'd0);
        end else begin
            chk("dom_rn", 32'(dom_rn), 32'(m_rn));
            chk("seq_idx", 32'(seq_idx), 32'(m_idx));
            chk("seq_busy", 32'(seq_busy), 32'(m_gap || m_wait));
            chk("seq_done", 32'(seq_done), 32'(m_done));
            chk("seq_err", 32'(seq_err), 32'(m_err));
        end
    endtask

    task automatic observe();
        for (int i = 0; i < NDOM; i++)
            if (dom_rn[i] === 1'b1 && prev_rn[i] !== 1'b1) rel_cyc[i] = cyc;
        if (seq_err === 1'b1 && prev_err !== 1'b1) err_cyc = cyc;
        if (seq_done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        if (seq_busy === 1'b1 && prev_busy !== 1'b1) busy_cyc = cyc;
        prev_rn = dom_rn; prev_err = seq_err; prev_done = seq_done; prev_busy = seq_busy;
    endtask

    task automatic clear_marks();
        for (int i = 0; i < NDOM; i++) rel_cyc[i] = NONE;
        err_cyc = NONE; done_cyc = NONE; busy_cyc = NONE;
    endtask

    task automatic drive();
        case (mode)
            0: dom_ack = 4'($urandom_range(0, 15));
            1: dom_ack = dom_rn;
            2: dom_ack = dom_rn & 4'b1011;
            3: dom_ack = (dom_rn & 4'b1101) | ((cyc == rel_cyc[1] + ATO - 1) ? 4'b0010 : 4'b0000);
            4: dom_ack = 4'b0000;
            5: dom_ack = dom_rn & 4'b1101;
            6: dom_ack = 4'($urandom_range(0, 15)) & ~(4'b0001 << seq_idx);
            default: begin
                dom_ack    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                sw_rst_req = ($urandom_range(0, 19) == 0);
                if (!RN) RN = ($urandom_range(0, 1) == 1);
                else if ($urandom_range(0, 299) == 0) RN = 1'b0;
            end
        endcase
    endtask

    // One clock: model and DUT see the same pre-edge inputs, new inputs after, check at negedge
    task automatic step();
        @(posedge CK);
        cyc++;
        model_edge();
        #1;
        drive();
        @(negedge CK);
        compare();
        observe();
    endtask

    task automatic sw_pulse();
        t_sw = cyc;
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_marks();

        // RN held low under random inputs
        mode = 0;
        for (int i = 0; i < 12; i++) begin
            sw_rst_req = ($urandom_range(0, 1) == 1);
            step();
        end
        sw_rst_req = 1'b0;
        chk("t2_dom_rn", 32'(dom_rn), 32'd0);
        chk("t2_flags", {29'd0, seq_busy, seq_done, seq_err}, 32'd0);

        // Nominal sequence, ack one cycle after each release
        e0 = cyc; RN = 1'b1; mode = 1; clear_marks();
        for (int i = 0; i < 100 && seq_done !== 1'b1; i++) step();
        chk("t1_busy_edge", 32'(busy_cyc - e0), 32'd3);
        chk("t1_rel0_edge", 32'(rel_cyc[0] - e0), 32'd11);
        chk("t1_rel3_edge", 32'(rel_cyc[3] - e0), 32'd38);
        chk("t1_done_edge", 32'(done_cyc - e0), 32'd39);
        chk("t1_dom_rn", 32'(dom_rn), 32'hF);
        chk("t1_busy_low", 32'(seq_busy), 32'd0);

        // Soft re-reset from DONE, then sw_rst_req held in WAIT
        mode = 4; clear_marks();
        sw_pulse();
        chk("t5_dom_rn_clr", 32'(dom_rn), 32'd0);
        chk("t5_done_clr", 32'(seq_done), 32'd0);
        for (int i = 0; i < 20 && rel_cyc[0] == NONE; i++) step();
        chk("t5_rel0_gap", 32'(rel_cyc[0] - (t_sw + 1)), 32'(GAP));
        sw_rst_req = 1'b1;
        for (int i = 0; i < 10; i++) step();
        sw_rst_req = 1'b0;
        chk("t5_wait_hold", {27'd0, dom_rn, seq_busy}, {27'd0, 4'b0001, 1'b1});
        mode = 1;
        for (int i = 0; i < 100 && seq_done !== 1'b1; i++) step();
        chk("t5_done", 32'(seq_done), 32'd1);

        // Domain 2 never acknowledges
        mode = 2; clear_marks();
        sw_pulse();
        for (int i = 0; i < 400 && seq_err !== 1'b1; i++) step();
        chk("t3_err_delay", 32'(err_cyc - rel_cyc[2]), 32'(ATO));
        chk("t3_dom_rn", 32'(dom_rn), 32'h7);
        chk("t3_seq_idx", 32'(seq_idx), 32'd2);
        chk("t3_busy", 32'(seq_busy), 32'd0);
        for (int i = 0; i < 5; i++) step();

        // Ack on the final WAIT edge beats the timeout
        mode = 3; clear_marks();
        sw_pulse();
        for (int i = 0; i < 600 && seq_done !== 1'b1; i++) step();
        chk("t4_no_err", 32'(err_cyc), 32'(NONE));
        chk("t4_rel_spacing", 32'(rel_cyc[2] - rel_cyc[1]), 32'(ATO + GAP));
        chk("t4_done", 32'(seq_done), 32'd1);

        // Wrong-index acks in WAIT of domain 1, then RN glitch and full restart
        mode = 5; clear_marks();
        sw_pulse();
        for (int i = 0; i < 60 && rel_cyc[1] == NONE; i++) step();
        mode = 6;
        for (int i = 0; i < 12; i++) step();
        chk("t6_stuck_idx", 32'(seq_idx), 32'd1);
        chk("t6_stuck_rn", 32'(dom_rn), 32'h3);
        RN = 1'b0;
        #1;
        chk("t6_async_rn", 32'(dom_rn), 32'd0);
        chk("t6_async_flags", {29'd0, seq_busy, seq_done, seq_err}, 32'd0);
        mode = 0;
        for (int i = 0; i < 3; i++) step();
        e0 = cyc; RN = 1'b1; mode = 1; clear_marks();
        for (int i = 0; i < 100 && seq_done !== 1'b1; i++) step();
        chk("t6_rel0_edge", 32'(rel_cyc[0] - e0), 32'd11);
        chk("t6_done_edge", 32'(done_cyc - e0), 32'd39);

        // Randomized soak against the model
        mode = 7;
        for (int i = 0; i < 3000; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
